// File: rtl/nios2_mul_cell_pipe.sv
// Pipelined multiply/shift cell for the Nios II custom-core execute path.
// Optional multiply-accumulate build: define NIOS2_MUL_CELL_MAC_EN.
module nios2_mul_cell_pipe #(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic              in_src1_signed,
  input  logic              in_src2_signed,
  input  logic              in_shift_right,
  input  logic              in_rotate,
  input  logic              acc_clr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam int SH_W = $clog2(DATA_W);
  localparam logic [SH_W:0] W_L = (SH_W+1)'(DATA_W);
`ifdef NIOS2_MUL_CELL_MAC_EN
  localparam int ST_W = 2*DATA_W;
`else
  localparam int ST_W = DATA_W;
`endif

  logic                advance;
  logic                accept;
  logic [2*DATA_W-1:0] ext_a;
  logic [2*DATA_W-1:0] ext_b;
  logic [2*DATA_W-1:0] prod;
  logic [SH_W-1:0]     sh;
  logic [SH_W:0]       sh_wrap;
  logic [SH_W-1:0]     rot_amt;
  logic [DATA_W-1:0]   shl;
  logic [DATA_W-1:0]   srl;
  logic [DATA_W-1:0]   sra;
  logic [2*DATA_W-1:0] rol_w;
  logic [2*DATA_W-1:0] ror_w;
  logic [DATA_W-1:0]   shift_res;
  logic [DATA_W-1:0]   res_w;
  logic [ST_W-1:0]     st_in;

  logic [PIPE_STAGES-1:0] vld;
  logic [ST_W-1:0]        dat [PIPE_STAGES];

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance & ~flush;
  assign accept   = in_valid & in_ready;

  // Full-width product; the sign/zero extension makes all four signedness mixes exact.
  assign ext_a = {{DATA_W{in_src1_signed & in_src1[DATA_W-1]}}, in_src1};
  assign ext_b = {{DATA_W{in_src2_signed & in_src2[DATA_W-1]}}, in_src2};
  assign prod  = ext_a * ext_b;

  assign sh      = in_src2[SH_W-1:0];
  assign sh_wrap = {1'b0, sh} - W_L;
  assign rot_amt = ({1'b0, sh} >= W_L) ? sh_wrap[SH_W-1:0] : sh;

  assign shl   = in_src1 << sh;
  assign srl   = in_src1 >> sh;
  assign sra   = $signed(in_src1) >>> sh;
  assign rol_w = {in_src1, in_src1} << rot_amt;
  assign ror_w = {in_src1, in_src1} >> rot_amt;

  always_comb begin
    shift_res = shl;
    if (in_rotate)
      shift_res = in_shift_right ? ror_w[DATA_W-1:0] : rol_w[2*DATA_W-1:DATA_W];
    else if (in_shift_right)
      shift_res = in_src1_signed ? sra : srl;
  end

  always_comb begin
    res_w = prod[DATA_W-1:0];
    case (in_op)
      2'b01:   res_w = prod[2*DATA_W-1:DATA_W];
      2'b10:   res_w = shift_res;
      default: res_w = prod[DATA_W-1:0];
    endcase
  end

`ifdef NIOS2_MUL_CELL_MAC_EN
  // MAC slots carry the whole product so the accumulate can happen at completion.
  always_comb begin
    st_in = {{DATA_W{1'b0}}, res_w};
    if (in_op == 2'b11)
      st_in = prod;
  end
`else
  assign st_in = res_w;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      for (int i = 0; i < PIPE_STAGES; i++)
        dat[i] <= '0;
    end else begin
      if (flush) begin
        vld <= '0;
      end else if (advance) begin
        vld[0] <= accept;
        for (int i = 1; i < PIPE_STAGES; i++)
          vld[i] <= vld[i-1];
      end
      if (advance) begin
        dat[0] <= st_in;
        for (int i = 1; i < PIPE_STAGES; i++)
          dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[PIPE_STAGES-1];

`ifdef NIOS2_MUL_CELL_MAC_EN
  logic [PIPE_STAGES-1:0] mac_q;
  logic [2*DATA_W-1:0]    acc;
  logic [2*DATA_W-1:0]    sum;
  logic [2*DATA_W-1:0]    mac_view;
  logic                   mac_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mac_q <= '0;
    end else if (advance) begin
      mac_q[0] <= (in_op == 2'b11);
      for (int i = 1; i < PIPE_STAGES; i++)
        mac_q[i] <= mac_q[i-1];
    end
  end

  assign sum      = acc + dat[PIPE_STAGES-1];
  assign mac_done = out_valid & out_ready & ~flush & mac_q[PIPE_STAGES-1];
  assign mac_view = acc_clr ? dat[PIPE_STAGES-1] : sum;
  assign out_data = mac_q[PIPE_STAGES-1] ? mac_view[DATA_W-1:0]
                                         : dat[PIPE_STAGES-1][DATA_W-1:0];

  // A clear that lands on a completing MAC leaves just that product behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      acc <= '0;
    else if (acc_clr)
      acc <= mac_done ? dat[PIPE_STAGES-1] : '0;
    else if (mac_done)
      acc <= sum;
  end
`else
  logic unused_acc_clr;
  assign unused_acc_clr = acc_clr;
  assign out_data       = dat[PIPE_STAGES-1];
`endif

endmodule
